usart_tx_arbiter: RTL

USART_TX_ARBITER -- requirements
Module: usart_tx_arbiter

---
 rtl/usart_tx_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/usart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// usart_tx_arbiter
//
// Shares one byte-wide USART transmitter between NUM_REQ requesters.
// The arbiter has two states:
//   IDLE : looks for pending requesters, picks a winner, latches its byte.
//   SEND : presents the latched byte to the transmitter until it is accepted.
//
// Arbitration is round-robin by default. The search starts one above the most
// recent owner and wraps, so a requester holding req_valid cannot win twice in
// a row while anyone else is waiting.
//
// Build option:
//   USART_TX_ARB_FIXED_PRIORITY_EN - when defined, the lowest-indexed pending
//   requester always wins and no last-grant history is kept.
//
// Parameters:
//   NUM_REQ   number of requesters (2..16)
//   IDX_W     grant index width, $clog2(NUM_REQ)
//
// Ports:
//   comm_clock  in   single clock, rising edge
//   reset       in   synchronous, active-high reset
//   req_valid   in   [NUM_REQ]   per-requester byte pending
//   req_data    in   [8*NUM_REQ] requester i byte on [8i+7:8i]
//   req_ready   out  [NUM_REQ]   one-cycle pulse: requester's byte accepted
//   tx_data     out  [8]         byte to the transmitter
//   tx_valid    out  1           byte valid to the transmitter
//   tx_ready    in   1           transmitter accept pulse
//   busy        out  1           a byte is owned by the arbiter (SEND)
//   grant       out  [IDX_W]     current or most recent owner
// -----------------------------------------------------------------------------
module usart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                   comm_clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic [IDX_W-1:0]       grant
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e               state_q;
  logic [7:0]           tx_data_q;
  logic [IDX_W-1:0]     grant_q;
  logic [NUM_REQ-1:0]   req_ready_q;

  // Arbitration result for the current cycle, consumed only in IDLE.
  logic                 any_req_d;
  logic [IDX_W-1:0]     win_idx_d;
  logic [7:0]           win_data_d;

  assign any_req_d = |req_valid;

`ifdef USART_TX_ARB_FIXED_PRIORITY_EN

  // Lowest pending index wins: scan downward so the last hit is the lowest.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment; otherwise the no-request path would infer a latch.
    win_idx_d = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_idx_d = IDX_W'(i);
      end
    end
  end

`else

  // Reset value makes requester 0 the first candidate after reset.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]     last_grant_q;
  logic [IDX_W-1:0]     cand_d;
  logic                 found_d;

  // Round-robin: candidates last_grant+1, +2, ... wrapping through NUM_REQ-1
  // to 0. The previous owner is visited last, which is what keeps a requester
  // holding req_valid from winning back-to-back against other pending ones.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment; otherwise the no-request path would infer a latch.
    win_idx_d = '0;
    found_d   = 1'b0;
    cand_d    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_d = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!found_d && req_valid[cand_d]) begin
        win_idx_d = cand_d;
        found_d   = 1'b1;
      end
    end
  end

  // Grant history lives in its own register so the FSM below stays identical
  // in both builds. It only moves when a byte is actually accepted, so a
  // reset-abandoned byte does not count as a turn.
  always_ff @(posedge comm_clock) begin
    if (reset) begin
      last_grant_q <= LAST_IDX;
    end else if (state_q == SEND && tx_ready) begin
      last_grant_q <= grant_q;
    end
  end

`endif

  // Byte mux for the winner. Compared against constant indices so the part
  // select never depends on a variable width.
  always_comb begin
    win_data_d = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx_d == IDX_W'(i)) begin
        win_data_d = req_data[8*i +: 8];
      end
    end
  end

  // Main FSM. Reset is checked first so it wins over a coincident tx_ready:
  // the byte is abandoned and no req_ready pulse is produced.
  always_ff @(posedge comm_clock) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q     <= IDLE;
      tx_data_q   <= 8'h00;
      grant_q     <= '0;
      req_ready_q <= '0;
    end else begin
      // req_ready is a single-cycle pulse; clear it unless set below.
      req_ready_q <= '0;
      case (state_q)
        IDLE: begin
          // tx_ready is ignored here by construction.
          if (any_req_d) begin
            tx_data_q <= win_data_d;
            grant_q   <= win_idx_d;
            state_q   <= SEND;
          end
        end
        SEND: begin
          // tx_data_q and grant_q are held; req_valid/req_data changes of the
          // owner are not looked at until the byte is accepted.
          if (tx_ready) begin
            req_ready_q[grant_q] <= 1'b1;
            state_q              <= IDLE;
          end
        end
      endcase
    end
  end

  assign tx_valid  = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign tx_data   = tx_data_q;
  assign grant     = grant_q;
  assign req_ready = req_ready_q;

endmodule
